// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack subset search: default sizes,
// controller state encoding and the item table entry layout.
package knap_pkg;

    localparam int unsigned KNAP_N_ITEMS = 7;
    localparam int unsigned KNAP_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Item table entries are stored at KNAP_W bits; instances with a
    // narrower W use the low W bits of each field.
    typedef struct packed {
        logic [KNAP_W-1:0] value;
        logic [KNAP_W-1:0] weight;
    } item_t;

endpackage

// File: rtl/knap_eval.sv
// Subset evaluator: sums the values and weights of the selected items
// (modulo 2^W) and presents the totals one clock later.
module knap_eval
    import knap_pkg::*;
#(
    parameter int unsigned N_ITEMS = KNAP_N_ITEMS,
    parameter int unsigned W       = KNAP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  item_t              items_i [N_ITEMS],
    input  logic [N_ITEMS-1:0] sel_i,
    output logic [W-1:0]       value_o,
    output logic [W-1:0]       weight_o
);

    logic [W-1:0] value_d;
    logic [W-1:0] weight_d;

    // Combinational subset sums; wrap-around is intentional.
    always_comb begin
        value_d  = '0;
        weight_d = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (sel_i[i]) begin
                value_d  = value_d + W'(items_i[i].value);
                weight_d = weight_d + W'(items_i[i].weight);
            end
        end
    end

    // Pipeline register holding the totals of the previous selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_o  <= '0;
            weight_o <= '0;
        end else begin
            value_o  <= value_d;
            weight_o <= weight_d;
        end
    end

endmodule

// File: rtl/knap_search.sv
// Exhaustive subset search over a small item table. Candidates are
// issued one per cycle, summed in knap_eval, and compared a cycle later.
// Build option KNAP_BEST_EN: keep the highest-value valid selection
// (ties go to the lowest index); otherwise stop at the first valid one.
module knap_search
    import knap_pkg::*;
#(
    parameter int unsigned N_ITEMS = KNAP_N_ITEMS,
    parameter int unsigned W       = KNAP_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic [$clog2(N_ITEMS)-1:0] cfg_idx,
    input  logic [W-1:0]               cfg_value,
    input  logic [W-1:0]               cfg_weight,
    input  logic [W-1:0]               min_value,
    input  logic [W-1:0]               max_weight,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [N_ITEMS-1:0]         best_sel,
    output logic [W-1:0]               best_value,
    output logic [W-1:0]               best_weight
);

    state_e             state_q, state_d;
    logic [N_ITEMS-1:0] cnt_q, cnt_d;
    logic [W-1:0]       min_q, min_d;
    logic [W-1:0]       max_q, max_d;
    item_t              table_q [N_ITEMS];
    item_t              table_d [N_ITEMS];
    logic               vld_q, vld_d;
    logic [N_ITEMS-1:0] tag_q, tag_d;
    logic               found_q, found_d;
    logic [N_ITEMS-1:0] sel_q, sel_d;
    logic [W-1:0]       bval_q, bval_d;
    logic [W-1:0]       bwt_q, bwt_d;
    logic [W-1:0]       sum_value, sum_weight;
    logic               cand_ok;

    knap_eval #(
        .N_ITEMS (N_ITEMS),
        .W       (W)
    ) u_eval (
        .clk      (clk),
        .rst_n    (rst_n),
        .items_i  (table_q),
        .sel_i    (cnt_q),
        .value_o  (sum_value),
        .weight_o (sum_weight)
    );

    // vld_q/tag_q track which candidate the evaluator totals belong to.
    assign cand_ok = vld_q && (sum_value >= min_q) && (sum_weight <= max_q);

    // Next-state, table write, candidate issue and best-result update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        min_d   = min_q;
        max_d   = max_q;
        table_d = table_q;
        vld_d   = (state_q == ST_SCAN);
        tag_d   = cnt_q;
        found_d = found_q;
        sel_d   = sel_q;
        bval_d  = bval_q;
        bwt_d   = bwt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_we && (32'(cfg_idx) < N_ITEMS)) begin
                    table_d[cfg_idx].value  = KNAP_W'(cfg_value);
                    table_d[cfg_idx].weight = KNAP_W'(cfg_weight);
                end
                if (start) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    min_d   = min_value;
                    max_d   = max_weight;
                    found_d = 1'b0;
                    sel_d   = '0;
                    bval_d  = '0;
                    bwt_d   = '0;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + N_ITEMS'(1);
                if (cnt_q == '1) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // The last candidate's totals arrive during DRAIN, so compare there too.
        if (((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && cand_ok) begin
`ifdef KNAP_BEST_EN
            if (!found_q || (sum_value > bval_q)) begin
                found_d = 1'b1;
                sel_d   = tag_q;
                bval_d  = sum_value;
                bwt_d   = sum_weight;
            end
`else
            if (!found_q) begin
                found_d = 1'b1;
                sel_d   = tag_q;
                bval_d  = sum_value;
                bwt_d   = sum_weight;
                state_d = ST_DONE;
            end
`endif
        end
    end

    // State, table, thresholds and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
            table_q <= '{default: '0};
            vld_q   <= 1'b0;
            tag_q   <= '0;
            found_q <= 1'b0;
            sel_q   <= '0;
            bval_q  <= '0;
            bwt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            min_q   <= min_d;
            max_q   <= max_d;
            table_q <= table_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            found_q <= found_d;
            sel_q   <= sel_d;
            bval_q  <= bval_d;
            bwt_q   <= bwt_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign found       = found_q;
    assign best_sel    = sel_q;
    assign best_value  = bval_q;
    assign best_weight = bwt_q;

endmodule
